// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enigma_pkg
// Description : Shared constants and helpers for the Enigma cipher core:
//               wheel I/II/III wirings and inverses, reflector B, notches,
//               mod-26 arithmetic and the core FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package enigma_pkg;

    localparam int ALPHA = 26;

    // Turnover letters: wheel II turns the left wheel at E, wheel III turns
    // the middle wheel at V. Wheel I's notch has no effect with three wheels.
    localparam logic [4:0] NOTCH_I   = 5'd16;
    localparam logic [4:0] NOTCH_II  = 5'd4;
    localparam logic [4:0] NOTCH_III = 5'd21;

    // Wheel I   : EKMFLGDQVZNTOWYHXUSPAIBRCJ
    localparam logic [4:0] WIRE_I [26] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam logic [4:0] WIRE_I_INV [26] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
        5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};

    // Wheel II  : AJDKSIRUXBLHWTMCQGZNPYFVOE
    localparam logic [4:0] WIRE_II [26] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
        5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam logic [4:0] WIRE_II_INV [26] = '{
        5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
        5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};

    // Wheel III : BDFHJLCPRTXVZNYEIWGAKMUSQO
    localparam logic [4:0] WIRE_III [26] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    localparam logic [4:0] WIRE_III_INV [26] = '{
        5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
        5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

    // Reflector B : YRUHQSLDPXNGOKMIEBFZCWVJAT
    localparam logic [4:0] REFLECTOR_B [26] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23, 5'd13, 5'd6,  5'd14,
        5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};

    typedef enum logic [1:0] {
        WHEEL_I   = 2'd0,
        WHEEL_II  = 2'd1,
        WHEEL_III = 2'd2
    } wheel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    // (a + b) mod 26 for operands already in 0..25
    function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 6'(ALPHA)) begin
            sum = sum - 6'(ALPHA);
        end
        return sum[4:0];
    endfunction

    // (a - b) mod 26 for operands already in 0..25; the 5-bit wrap of a+26
    // cancels out because the final result always lies in 1..25
    function automatic logic [4:0] mod26_sub(input logic [4:0] a, input logic [4:0] b);
        if (a < b) begin
            return a + 5'(ALPHA) - b;
        end
        return a - b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enigma_rotor_map.sv
`default_nettype none
// ============================================================================
// Module      : enigma_rotor_map
// Description : Combinational single-wheel substitution. Offsets the letter
//               by the wheel position, looks up the forward or inverse
//               wiring, and removes the offset again.
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_rotor_map
    import enigma_pkg::*;
(
    input  logic [4:0] i_letter,
    input  logic [4:0] i_pos,
    input  wheel_t     i_wheel,
    input  logic       i_backward,
    output logic [4:0] o_letter
);

    logic [4:0] w_contact;
    logic [4:0] w_wired;

    // Select the wiring table for the requested wheel and direction
    always_comb begin
        w_contact = mod26_add(i_letter, i_pos);
        case (i_wheel)
            WHEEL_I:  w_wired = i_backward ? WIRE_I_INV[w_contact]  : WIRE_I[w_contact];
            WHEEL_II: w_wired = i_backward ? WIRE_II_INV[w_contact] : WIRE_II[w_contact];
            default:  w_wired = i_backward ? WIRE_III_INV[w_contact] : WIRE_III[w_contact];
        endcase
    end

    assign o_letter = mod26_sub(w_wired, i_pos);

endmodule
`default_nettype wire

// File: rtl/enigma_core.sv
`default_nettype none
// ============================================================================
// Module      : enigma_core
// Description : Three-wheel Enigma I cipher (wheels I-II-III, reflector B,
//               rings at A, no plugboard). One letter per handshake, stepped
//               and then substituted one wheel per cycle; 8-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_core
    import enigma_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        data_valid_in,
    input  logic [4:0]  data_in,
    output logic        ready_out,
    input  logic        load_valid_in,
    input  logic [14:0] pos_in,
    output logic        data_valid_out,
    output logic [4:0]  data_out,
    output logic [14:0] pos_out
);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [4:0] r_c;
    logic [4:0] r_pos_l;
    logic [4:0] r_pos_m;
    logic [4:0] r_pos_r;
    logic [4:0] r_data_out;
    logic       r_data_valid;

    logic [4:0] w_map_pos;
    wheel_t     w_map_wheel;
    logic       w_map_back;
    logic [4:0] w_map_out;
    logic [4:0] w_sub_next;

    // Out-of-range start positions are forced to A
    function automatic logic [4:0] clamp_letter(input logic [4:0] v);
        return (v < 5'(ALPHA)) ? v : 5'd0;
    endfunction

    // Route the shared wheel mapper: R, M, L forward then L, M, R backward
    always_comb begin
        w_map_pos   = r_pos_r;
        w_map_wheel = WHEEL_III;
        w_map_back  = 1'b0;
        case (r_idx)
            3'd1: begin w_map_pos = r_pos_m; w_map_wheel = WHEEL_II; end
            3'd2: begin w_map_pos = r_pos_l; w_map_wheel = WHEEL_I;  end
            3'd4: begin w_map_pos = r_pos_l; w_map_wheel = WHEEL_I;  w_map_back = 1'b1; end
            3'd5: begin w_map_pos = r_pos_m; w_map_wheel = WHEEL_II; w_map_back = 1'b1; end
            3'd6: begin w_map_back = 1'b1; end
            default: ;
        endcase
    end

    enigma_rotor_map u_rotor_map (
        .i_letter   (r_c),
        .i_pos      (w_map_pos),
        .i_wheel    (w_map_wheel),
        .i_backward (w_map_back),
        .o_letter   (w_map_out)
    );

    // Middle substitution slot is the reflector, read directly
    assign w_sub_next = (r_idx == 3'd3) ? REFLECTOR_B[r_c] : w_map_out;

    // Control FSM, rotor stepping and registered cipher output
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_idx        <= 3'd0;
            r_c          <= 5'd0;
            r_pos_l      <= 5'd0;
            r_pos_m      <= 5'd0;
            r_pos_r      <= 5'd0;
            r_data_out   <= 5'd0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_valid_in) begin
                        r_pos_l <= clamp_letter(pos_in[14:10]);
                        r_pos_m <= clamp_letter(pos_in[9:5]);
                        r_pos_r <= clamp_letter(pos_in[4:0]);
                    end else if (data_valid_in && (data_in < 5'(ALPHA))) begin
                        r_c     <= data_in;
                        r_state <= STEP;
                    end
                end
                STEP: begin
                    // Decisions use pre-step positions; M==E gives the double step
                    r_pos_r <= mod26_add(r_pos_r, 5'd1);
                    if ((r_pos_r == NOTCH_III) || (r_pos_m == NOTCH_II)) begin
                        r_pos_m <= mod26_add(r_pos_m, 5'd1);
                    end
                    if (r_pos_m == NOTCH_II) begin
                        r_pos_l <= mod26_add(r_pos_l, 5'd1);
                    end
                    r_idx   <= 3'd0;
                    r_state <= SUB;
                end
                SUB: begin
                    r_c <= w_sub_next;
                    if (r_idx == 3'd6) begin
                        r_data_out   <= w_sub_next;
                        r_data_valid <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready_out      = (r_state == IDLE) && !load_valid_in;
    assign data_valid_out = r_data_valid;
    assign data_out       = r_data_out;
    assign pos_out        = {r_pos_l, r_pos_m, r_pos_r};

endmodule
`default_nettype wire
